cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Shares the CPU's single-port 16 x 8 data/instruction memory between several requesters (instruction fetch, load/store unit, debug/loader port). Requests are granted round-robin and serialised into one memory access at a time; each access produces a one-cycle response pulse back to its owner. The block sits between the CPU core and the memory, driving the memory's `cs`/`we` strobes.

## Interface
- `NREQ`, 3: number of requesters. Index 0 is fetch, 1 is load/store, 2 is debug.
- `AW`, 4: memory address width.
- `DW`, 8: data width.
- `MEM_LAT`, 1: cycles from the `mem_cs` cycle to `mem_rdata` being valid. Must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_we` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ*AW: requester i uses `[i*AW +: AW]`.
- `req_wdata` in NREQ*DW: requester i uses `[i*DW +: DW]`.
- `req_ready` out NREQ: one-hot, one-cycle pulse; the request is accepted.
- `rsp_valid` out NREQ: one-hot, one-cycle pulse; the access is complete.
- `rsp_rdata` out DW: read data, valid with `rsp_valid`. It is 0 for writes.
- `mem_cs` out 1: memory select.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is set, pick a winner round-robin. The search starts at `last_grant+1` (mod NREQ) and takes the first set bit.
  - Latch the winner's index, `we`, `addr` and `wdata`, then go to ISSUE.
  - With no requests, stay in IDLE.
- **ISSUE** (one cycle)
  - Drive `mem_cs=1` with `mem_we`, `mem_addr` and `mem_wdata` from the latches.
  - Pulse `req_ready[g]`.
  - Update `last_grant` to g.
  - Load the wait counter with MEM_LAT.
- **WAIT** (exactly MEM_LAT cycles)
  - Decrement the counter each cycle.
  - On the final cycle (counter = 1), capture `mem_rdata` if the access is a read; capture 0 if it is a write.
- **RESP** (one cycle): pulse `rsp_valid[g]` and drive `rsp_rdata` with the captured value. Return to IDLE.
- The requester holds `req_valid`, `we`, `addr` and `wdata` stable until it sees `req_ready`. The requester then deasserts `req_valid` in the following cycle, unless it has a new request.
- `req_valid` is sampled only in IDLE. Changes while the arbiter is busy are ignored until the next IDLE.
- A requester that deasserts `req_valid` before being granted is simply skipped.
- All `mem_*` outputs are 0 outside ISSUE. `mem_cs` is never high for more than one consecutive cycle.
- Address arithmetic: none. Addresses pass through unchanged, and wrap-around is the memory's concern.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = NREQ-1, so requester 0 wins first.
  - `req_ready`, `rsp_valid`, `rsp_rdata`, `busy` and all `mem_*` outputs are 0.
- Let request sampling in IDLE be cycle T:
  - `req_ready` and `mem_cs` are high in cycle T+1.
  - WAIT occupies cycles T+2 .. T+1+MEM_LAT.
  - `rsp_valid` is high in cycle T+2+MEM_LAT.
  - IDLE is re-entered at T+3+MEM_LAT.
- Peak throughput is one access per MEM_LAT+3 cycles.
- Simultaneous requests: resolved strictly round-robin. A requester re-requesting immediately after its response waits behind all other pending requesters.
- Reset asserted mid-access: return to IDLE on the next edge. The aborted access gives no `rsp_valid` and the captured data is discarded. Requests still asserted after reset are re-arbitrated from requester 0.

## Structure
- Shared package `cpu_pkg` holds:
  - constants `CPU_AW=4`, `CPU_DW=8`, `CPU_NREQ=3`;
  - requester index constants `REQ_FETCH=0`, `REQ_LSU=1`, `REQ_DBG=2`;
  - the arbiter state enum `arb_state_t` (IDLE, ISSUE, WAIT, RESP).
- Sub-module `rr_picker`: combinational block with inputs `req[NREQ]` and `last[clog2(NREQ)]`, and outputs `found` and `idx`. Reusable for other shared CPU resources.

## Test plan
- **Single read:** reset, then preload mem[0x06]=0x0C and raise `req_valid[1]` with read addr 0x06. Expect `req_ready[1]` at T+1, `mem_cs`=1/`mem_we`=0/`mem_addr`=0x6 in that cycle, and `rsp_valid[1]` with `rsp_rdata`=0x0C at T+3 (MEM_LAT=1).
- **Write then read:** requester 2 writes 0x0F to addr 0x0F, then requester 0 reads 0x0F. Expect `mem_we`=1 with `mem_wdata`=0x0F on the write and `rsp_rdata`=0x00; then `rsp_rdata`=0x0F on the read.
- **All three requesting continuously from reset:** grants follow the order 0,1,2,0,1,2. The gap between successive `req_ready` pulses is exactly MEM_LAT+3 cycles, and `mem_cs` is never high for two adjacent cycles.
- **Reset mid-access:** assert `reset` during WAIT. Expect no `rsp_valid`, all outputs 0 on the next cycle, and the first grant afterwards going to requester 0.
- **Latency sweep:** with MEM_LAT=3, a read returns `rsp_valid` at T+5 with data captured in cycle T+4. Also, a `req_valid` withdrawn before grant is never granted and produces no `mem_cs`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants, requester indices and the memory arbiter state encoding.
package cpu_pkg;

    localparam int unsigned CPU_AW   = 4;
    localparam int unsigned CPU_DW   = 8;
    localparam int unsigned CPU_NREQ = 3;

    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_LSU   = 1;
    localparam int unsigned REQ_DBG   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping at NREQ.
module rr_picker
    import cpu_pkg::*;
#(
    parameter int unsigned NREQ = CPU_NREQ
) (
    input  logic [NREQ-1:0]                             req,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  last,
    output logic                                        found,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  idx
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Walk offsets from farthest to nearest so the closest hit after 'last' is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            logic [IW-1:0] j;
            j = IW'((32'(last) + k) % NREQ);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter serialising fetch / load-store / debug accesses onto the CPU's
// single-port memory, one access per MEM_LAT+3 cycles with a one-cycle response pulse.
module cpu_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NREQ    = CPU_NREQ,
    parameter int unsigned AW      = CPU_AW,
    parameter int unsigned DW      = CPU_DW,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MEM_LAT + 1);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NREQ-1:0]  req_ready_q, req_ready_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic             mem_cs_q, mem_cs_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             busy_q, busy_d;

    logic             pick_found;
    logic [IW-1:0]    pick_idx;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req   (req_valid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state logic; output registers are loaded from the state being entered.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    we_d    = req_we[pick_idx];
                    addr_d  = req_addr[32'(pick_idx) * AW +: AW];
                    wdata_d = req_wdata[32'(pick_idx) * DW +: DW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                last_d  = gnt_q;
                cnt_d   = CW'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rsp_rdata_d = we_q ? '0 : mem_rdata;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ISSUE) begin
            req_ready_d = NREQ'(1) << gnt_d;
            mem_cs_d    = 1'b1;
            mem_we_d    = we_d;
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end
        if (state_d == RESP) begin
            rsp_valid_d = NREQ'(1) << gnt_d;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            gnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench: MEM_LAT=1 and MEM_LAT=3 arbiters, each with its own behavioural memory.
module tb_cpu_mem_arbiter;
    import cpu_pkg::*;

    localparam int unsigned N  = CPU_NREQ;
    localparam int unsigned AW = CPU_AW;
    localparam int unsigned DW = CPU_DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset1, reset3;
    logic [N-1:0]    req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;

    logic [N-1:0]  ready1, rspv1, ready3, rspv3;
    logic [DW-1:0] rdata1, rdata3, wdata1, wdata3, mrdata1, mrdata3;
    logic [AW-1:0] addr1, addr3;
    logic          cs1, we1, busy1, cs3, we3, busy3;

    cpu_mem_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready1),
        .rsp_valid(rspv1), .rsp_rdata(rdata1), .mem_cs(cs1), .mem_we(we1),
        .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(mrdata1), .busy(busy1)
    );

    cpu_mem_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready3),
        .rsp_valid(rspv3), .rsp_rdata(rdata3), .mem_cs(cs3), .mem_we(we3),
        .mem_addr(addr3), .mem_wdata(wdata3), .mem_rdata(mrdata3), .busy(busy3)
    );

    // Memories: read data appears exactly MEM_LAT cycles after the cs cycle, zero otherwise.
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] mem3 [16];
    logic [DW-1:0] p1 = '0, p3a = '0, p3b = '0, p3c = '0;

    always @(posedge clk) begin
        if (pl_we) mem1[pl_addr] <= pl_data;
        else if (cs1 && we1) mem1[addr1] <= wdata1;
        p1 <= (cs1 && !we1) ? mem1[addr1] : '0;
    end

    always @(posedge clk) begin
        if (pl_we) mem3[pl_addr] <= pl_data;
        else if (cs3 && we3) mem3[addr3] <= wdata3;
        p3a <= (cs3 && !we3) ? mem3[addr3] : '0;
        p3b <= p3a;
        p3c <= p3b;
    end

    assign mrdata1 = p1;
    assign mrdata3 = p3c;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int unsigned i);
        return N'(1) << i;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    typedef struct {
        int unsigned   r;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [7];

    // One isolated access on the MEM_LAT=1 arbiter, checked cycle by cycle from T.
    task automatic run_vec(input int n, input vec_t v);
        req_valid = oh(v.r);
        req_we    = v.we ? oh(v.r) : '0;
        req_addr  = '0;
        req_wdata = '0;
        req_addr[v.r*AW +: AW]  = v.addr;
        req_wdata[v.r*DW +: DW] = v.wdata;
        tick();
        chk($sformatf("v%0d ready", n), 32'(ready1), 32'(oh(v.r)));
        chk($sformatf("v%0d cs", n), 32'(cs1), 32'd1);
        chk($sformatf("v%0d we", n), 32'(we1), 32'(v.we));
        chk($sformatf("v%0d addr", n), 32'(addr1), 32'(v.addr));
        chk($sformatf("v%0d wdata", n), 32'(wdata1), 32'(v.wdata));
        chk($sformatf("v%0d busy", n), 32'(busy1), 32'd1);
        req_valid = '0;
        tick();
        chk($sformatf("v%0d cs_wait", n), 32'(cs1), 32'd0);
        chk($sformatf("v%0d rspv_wait", n), 32'(rspv1), 32'd0);
        tick();
        chk($sformatf("v%0d rspv", n), 32'(rspv1), 32'(oh(v.r)));
        chk($sformatf("v%0d rdata", n), 32'(rdata1), 32'(v.rdata));
        tick();
        chk($sformatf("v%0d idle", n), 32'(busy1), 32'd0);
    endtask

    int unsigned g_idx [$];
    int          g_cyc [$];
    int          cs_adj;
    logic        prev_cs;

    initial begin
        vecs[0] = '{REQ_LSU,   1'b0, 4'h6, 8'h00, 8'h0C};
        vecs[1] = '{REQ_DBG,   1'b1, 4'hF, 8'h0F, 8'h00};
        vecs[2] = '{REQ_FETCH, 1'b0, 4'hF, 8'h00, 8'h0F};
        vecs[3] = '{REQ_LSU,   1'b1, 4'h3, 8'hA5, 8'h00};
        vecs[4] = '{REQ_DBG,   1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[5] = '{REQ_FETCH, 1'b1, 4'h0, 8'h5A, 8'h00};
        vecs[6] = '{REQ_LSU,   1'b0, 4'h0, 8'h33, 8'h5A};

        reset1 = 1'b1; reset3 = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        chk("rst ready", 32'(ready1), 32'd0);
        chk("rst rspv", 32'(rspv1), 32'd0);
        chk("rst rdata", 32'(rdata1), 32'd0);
        chk("rst busy", 32'(busy1), 32'd0);
        chk("rst mem", {cs1, we1, 2'b0, addr1, wdata1}, 32'd0);
        preload(4'h6, 8'h0C);
        preload(4'h9, 8'h3C);

        reset1 = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // All three requesting continuously from reset.
        reset1 = 1'b1;
        tick();
        reset1 = 1'b0;
        req_valid = 3'b111; req_we = '0; req_addr = {4'h6, 4'h6, 4'h6};
        cs_adj = 0; prev_cs = 1'b0;
        for (int c = 0; c < 40 && g_idx.size() < 6; c++) begin
            tick();
            if (prev_cs && cs1) cs_adj++;
            prev_cs = cs1;
            for (int unsigned b = 0; b < N; b++) begin
                if (ready1[b]) begin
                    g_idx.push_back(b);
                    g_cyc.push_back(c);
                end
            end
        end
        chk("rr grant count", 32'(g_idx.size()), 32'd6);
        for (int i = 0; i < g_idx.size(); i++)
            chk($sformatf("rr order %0d", i), 32'(g_idx[i]), 32'(i % 3));
        for (int i = 1; i < g_cyc.size(); i++)
            chk($sformatf("rr gap %0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
        chk("rr first grant cycle", 32'(g_cyc[0]), 32'd0);
        chk("rr cs adjacent", 32'(cs_adj), 32'd0);
        req_valid = '0;
        tick(); tick(); tick(); tick();

        // Reset asserted during WAIT after granting requester 1.
        req_valid = oh(REQ_LSU);
        tick();
        chk("ra ready", 32'(ready1), 32'(oh(REQ_LSU)));
        tick();
        chk("ra in wait", 32'(busy1), 32'd1);
        reset1 = 1'b1;
        tick();
        chk("ra rspv", 32'(rspv1), 32'd0);
        chk("ra outs", {ready1, busy1, cs1, we1, addr1, rdata1, wdata1}, 32'd0);
        reset1 = 1'b0;
        req_valid = 3'b111;
        tick();
        chk("ra regrant", 32'(ready1), 32'(oh(REQ_FETCH)));
        req_valid = '0;
        tick(); tick(); tick();

        // MEM_LAT=3 arbiter: read latency plus a request withdrawn before grant.
        reset1 = 1'b1;
        reset3 = 1'b0;
        tick();
        req_valid = oh(REQ_DBG); req_we = '0; req_addr = {4'h9, 4'h0, 4'h0}; req_wdata = '0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin
                chk("l3 ready", 32'(ready3), 32'(oh(REQ_DBG)));
                chk("l3 cs", 32'(cs3), 32'd1);
                chk("l3 addr", 32'(addr3), 32'h9);
                chk("l3 we", 32'(we3), 32'd0);
                req_valid = '0;
            end else if (c <= 4) begin
                chk($sformatf("l3 cs c%0d", c), 32'(cs3), 32'd0);
                chk($sformatf("l3 rspv c%0d", c), 32'(rspv3), 32'd0);
                chk($sformatf("l3 busy c%0d", c), 32'(busy3), 32'd1);
            end else if (c == 5) begin
                chk("l3 rspv", 32'(rspv3), 32'(oh(REQ_DBG)));
                chk("l3 rdata", 32'(rdata3), 32'h3C);
            end else begin
                chk($sformatf("wd ready c%0d", c), 32'(ready3), 32'd0);
                chk($sformatf("wd cs c%0d", c), 32'(cs3), 32'd0);
            end
            if (c == 2) begin
                req_valid = oh(REQ_FETCH);
                req_addr  = {4'h0, 4'h0, 4'h1};
            end
            if (c == 3) req_valid = '0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
